// File: rtl/sequential_multiplier.sv
// Iterative shift-add multiplier: N x N -> 2N over N+1 clocks, unsigned or
// two's-complement per operation, result held until the next completion.
module sequential_multiplier #(
   parameter int N = 4
) (
   input  logic           i_clock,
   input  logic           i_reset,
   input  logic           i_start,
   input  logic           i_signed,
   input  logic [N-1:0]   i_multiplicand,
   input  logic [N-1:0]   i_multiplier,
   output logic           o_busy,
   output logic           o_finished,
   output logic [2*N-1:0] o_product
);

   localparam int CW = (N > 2) ? $clog2(N) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [N-1:0]     a_q, a_d;
   logic             signed_q, signed_d;
   logic [N:0]       hi_q, hi_d;
   logic [N-1:0]     lo_q, lo_d;
   logic [2*N-1:0]   product_q, product_d;

   logic [N+1:0]     hi_ext, a_ext, sum;
   logic [N:0]       step_hi;
   logic [N-1:0]     step_lo;
   logic             last;

   always_comb begin
      // hi carries one guard bit so the add never overflows before the shift;
      // in signed mode the final multiplier bit has weight -2^(N-1), hence subtract.
      hi_ext  = signed_q ? {hi_q[N], hi_q} : {1'b0, hi_q};
      a_ext   = signed_q ? {{2{a_q[N-1]}}, a_q} : {2'b00, a_q};
      last    = (cnt_q == CW'(N - 1));
      if (lo_q[0])
         sum = (signed_q && last) ? (hi_ext - a_ext) : (hi_ext + a_ext);
      else
         sum = hi_ext;
      step_hi = sum[N+1:1];
      step_lo = {sum[0], lo_q[N-1:1]};
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      signed_d  = signed_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      product_d = product_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (i_start) begin
               state_d  = S_RUN;
               a_d      = i_multiplicand;
               lo_d     = i_multiplier;
               signed_d = i_signed;
               hi_d     = '0;
               cnt_d    = '0;
            end
         end
         S_RUN: begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
               state_d   = S_DONE;
               product_d = {step_hi[N-1:0], step_lo};
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         a_q       <= '0;
         signed_q  <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         a_q       <= a_d;
         signed_q  <= signed_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         product_q <= product_d;
      end
   end

   assign o_busy     = (state_q == S_RUN);
   assign o_finished = (state_q == S_DONE);
   assign o_product  = product_q;

endmodule

// File: tb/tb_sequential_multiplier.sv
// Directed bench for sequential_multiplier at N=4 and N=8.
module tb_sequential_multiplier;

   logic        clk = 1'b0;
   logic        rst;
   logic        start4, start8, sgn;
   logic [7:0]  opa, opb;
   logic        busy4, fin4, busy8, fin8;
   logic [7:0]  prod4;
   logic [15:0] prod8;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sequential_multiplier #(.N(4)) u_dut4 (
      .i_clock(clk), .i_reset(rst), .i_start(start4), .i_signed(sgn),
      .i_multiplicand(opa[3:0]), .i_multiplier(opb[3:0]),
      .o_busy(busy4), .o_finished(fin4), .o_product(prod4));

   sequential_multiplier #(.N(8)) u_dut8 (
      .i_clock(clk), .i_reset(rst), .i_start(start8), .i_signed(sgn),
      .i_multiplicand(opa), .i_multiplier(opb),
      .o_busy(busy8), .o_finished(fin8), .o_product(prod8));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic obs_busy(input int w);
      return (w == 8) ? busy8 : busy4;
   endfunction

   function automatic logic obs_fin(input int w);
      return (w == 8) ? fin8 : fin4;
   endfunction

   function automatic logic [15:0] obs_prod(input int w);
      return (w == 8) ? prod8 : {8'h00, prod4};
   endfunction

   // Present a start for one edge, then scramble the operand inputs.
   task automatic start_op(input int w, input logic s, input logic [7:0] a, input logic [7:0] b);
      start4 = (w == 4);
      start8 = (w == 8);
      sgn    = s;
      opa    = a;
      opb    = b;
      tick();
      start4 = 1'b0;
      start8 = 1'b0;
      sgn    = ~s;
      opa    = 8'($urandom);
      opb    = 8'($urandom);
   endtask

   // Called right after the accepting edge; waits (bounded) for o_finished.
   task automatic finish_op(input int w, input string tag, input logic [15:0] exp);
      int k = 0;
      while (!obs_fin(w) && k < 40) begin
         chk({tag, " busy"}, 32'(obs_busy(w)), 32'd1);
         tick();
         k++;
      end
      chk({tag, " latency"}, 32'(k), 32'(w));
      chk({tag, " product"}, 32'(obs_prod(w)), 32'(exp));
      chk({tag, " busy_done"}, 32'(obs_busy(w)), 32'd0);
   endtask

   typedef struct {
      int         w;
      logic       s;
      logic [7:0] a;
      logic [7:0] b;
      logic [15:0] p;
   } vec_t;

   vec_t vecs[11] = '{
      '{4, 1'b0, 8'h0F, 8'h0F, 16'h00E1},
      '{4, 1'b1, 8'h08, 8'h08, 16'h0040},
      '{4, 1'b0, 8'h08, 8'h08, 16'h0040},
      '{4, 1'b1, 8'h0D, 8'h05, 16'h00F1},
      '{4, 1'b1, 8'h07, 8'h0F, 16'h00F9},
      '{4, 1'b0, 8'h0D, 8'h05, 16'h0041},
      '{4, 1'b1, 8'h08, 8'h07, 16'h00C8},
      '{4, 1'b1, 8'h00, 8'h07, 16'h0000},
      '{8, 1'b1, 8'h80, 8'h80, 16'h4000},
      '{8, 1'b0, 8'hFF, 8'hFF, 16'hFE01},
      '{8, 1'b1, 8'hFF, 8'h80, 16'h0080}
   };

   initial begin
      rst = 1'b1; start4 = 1'b0; start8 = 1'b0; sgn = 1'b0; opa = '0; opb = '0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst busy4", 32'(busy4), 32'd0);
      chk("rst fin4", 32'(fin4), 32'd0);
      chk("rst prod4", 32'(prod4), 32'd0);
      chk("rst busy8", 32'(busy8), 32'd0);
      chk("rst prod8", 32'(prod8), 32'd0);

      foreach (vecs[i]) begin
         start_op(vecs[i].w, vecs[i].s, vecs[i].a, vecs[i].b);
         finish_op(vecs[i].w, $sformatf("vec%0d", i), vecs[i].p);
         tick();
         chk($sformatf("vec%0d pulse", i), 32'(obs_fin(vecs[i].w)), 32'd0);
         chk($sformatf("vec%0d hold", i), 32'(obs_prod(vecs[i].w)), 32'(vecs[i].p));
      end

      // Start during RUN is ignored; then a back-to-back start in DONE.
      start_op(4, 1'b0, 8'h03, 8'h04);
      tick();
      start4 = 1'b1; opa = 8'h09; opb = 8'h09;
      tick();
      start4 = 1'b0;
      tick();
      tick();
      chk("ign finished", 32'(fin4), 32'd1);
      chk("ign product", 32'(prod4), 32'h0C);
      start_op(4, 1'b0, 8'h02, 8'h06);
      chk("b2b busy", 32'(busy4), 32'd1);
      chk("b2b fin_low", 32'(fin4), 32'd0);
      chk("b2b hold", 32'(prod4), 32'h0C);
      finish_op(4, "b2b", 16'h000C);
      tick();

      // Reset mid-operation aborts with no finish pulse.
      start_op(4, 1'b0, 8'h0F, 8'h0F);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort busy", 32'(busy4), 32'd0);
      chk("abort fin", 32'(fin4), 32'd0);
      chk("abort prod", 32'(prod4), 32'd0);
      begin
         int pulses = 0;
         for (int i = 0; i < 6; i++) begin
            if (fin4 || busy4) pulses++;
            tick();
         end
         chk("abort quiet", 32'(pulses), 32'd0);
      end
      start_op(4, 1'b0, 8'h01, 8'h01);
      finish_op(4, "after_abort", 16'h0001);
      tick();

      // Reset and start on the same edge: reset wins.
      rst = 1'b1; start4 = 1'b1; opa = 8'h05; opb = 8'h05;
      tick();
      rst = 1'b0; start4 = 1'b0;
      chk("rst_start busy", 32'(busy4), 32'd0);
      tick();
      chk("rst_start idle", 32'(busy4), 32'd0);

      // Random N=8 pairs against a behavioural product.
      for (int i = 0; i < 12; i++) begin
         logic [7:0]  ra, rb;
         logic        rs;
         logic [15:0] ref_p;
         ra = 8'($urandom);
         rb = 8'($urandom);
         rs = 1'($urandom);
         if (rs) ref_p = 16'($signed({{8{ra[7]}}, ra}) * $signed({{8{rb[7]}}, rb}));
         else    ref_p = {8'h00, ra} * {8'h00, rb};
         start_op(8, rs, ra, rb);
         finish_op(8, $sformatf("rnd%0d", i), ref_p);
      end
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
